xclk_pll_sequencer: RTL

- Brings up and supervises the camera-clock PLL (50 MHz in, 12 MHz XCLK out) and the OV7670 power/reset pins.
- Pulses PLL reset, waits for a stable lock, and bounds retries.
- Then sequences camera PWDN/RESET timing, releases the system reset and issues a one-shot SCCB configuration start.
- Runs in the 50 MHz refclk domain, between the PLL wrapper, the camera pins and the SCCB config block.

---
 rtl/clk_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/xclk_pll_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
// Shared state encoding and timing defaults for the camera clock / power sequencer.
package clk_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CAM_RESET = 3'd3,
    CAM_WAKE  = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam int DEF_PLL_RST_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT    = 50000;
  localparam int DEF_LOCK_STABLE     = 1024;
  localparam int DEF_CAM_RST_CYCLES  = 50000;
  localparam int DEF_CAM_WAKE_CYCLES = 50000;
  localparam int DEF_MAX_RETRIES     = 3;

  // Counter must hold (largest period - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer for bringing an asynchronous level into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/xclk_pll_sequencer.sv
// Brings up the XCLK PLL, sequences OV7670 PWDN/RESET, then releases sys_rst
// and fires a one-shot SCCB configuration start. Supervises lock afterwards.
module xclk_pll_sequencer
  import clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
  parameter int CAM_RST_CYCLES  = DEF_CAM_RST_CYCLES,
  parameter int CAM_WAKE_CYCLES = DEF_CAM_WAKE_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       cam_pwdn,
  output logic       cam_reset_n,
  output logic       sys_rst,
  output logic       cfg_start,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE,
                                   CAM_RST_CYCLES, CAM_WAKE_CYCLES);

  localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CAM_RST_LAST  = CNT_W'(CAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAM_WAKE_LAST = CNT_W'(CAM_WAKE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX     = 2'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic             lock_s;
  logic             expire;
  logic             timed;
  logic             pll_rst_next, cam_pwdn_next, cam_reset_n_next;
  logic             sys_rst_next, cfg_start_next, ready_next, fault_next;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    expire     = 1'b0;

    case (state_reg)
      RESET_PLL: if (cnt_reg == PLL_RST_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                        state_next = STABLE;
        else if (cnt_reg == TIMEOUT_LAST)  expire = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                       expire = 1'b1;
        else if (cnt_reg == STABLE_LAST)   state_next = CAM_RESET;
      end
      CAM_RESET: begin
        if (!lock_s)                       expire = 1'b1;
        else if (cnt_reg == CAM_RST_LAST)  state_next = CAM_WAKE;
      end
      CAM_WAKE: begin
        if (!lock_s)                       expire = 1'b1;
        else if (cnt_reg == CAM_WAKE_LAST) begin
          state_next = RUN;
          retry_next = 2'd0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = RESET_PLL;
          retry_next = 2'd0;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = RESET_PLL;
    endcase

    // Retry budget: the attempt that finds retry_cnt already at the limit faults.
    if (expire) begin
      if (retry_reg == RETRY_MAX) begin
        state_next = FAULT;
      end else begin
        state_next = RESET_PLL;
        retry_next = retry_reg + 2'd1;
      end
    end

    if (restart) begin
      state_next = RESET_PLL;
      retry_next = 2'd0;
    end

    timed = (state_reg != RUN) && (state_reg != FAULT);
    if ((state_next != state_reg) || restart) cnt_next = '0;
    else if (timed)                           cnt_next = cnt_reg + CNT_W'(1);
    else                                      cnt_next = cnt_reg;

    // Pin levels follow the state being entered so they switch with the state.
    pll_rst_next     = (state_next == RESET_PLL) || (state_next == FAULT);
    cam_pwdn_next    = (state_next == RESET_PLL) || (state_next == WAIT_LOCK) ||
                       (state_next == STABLE)    || (state_next == FAULT);
    cam_reset_n_next = (state_next == CAM_WAKE)  || (state_next == RUN);
    sys_rst_next     = (state_next != RUN);
    ready_next       = (state_next == RUN);
    cfg_start_next   = (state_next == RUN) && (state_reg != RUN);
    fault_next       = (state_next == FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg   <= RESET_PLL;
      cnt_reg     <= '0;
      retry_reg   <= 2'd0;
      pll_rst     <= 1'b1;
      cam_pwdn    <= 1'b1;
      cam_reset_n <= 1'b0;
      sys_rst     <= 1'b1;
      cfg_start   <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      pll_rst     <= pll_rst_next;
      cam_pwdn    <= cam_pwdn_next;
      cam_reset_n <= cam_reset_n_next;
      sys_rst     <= sys_rst_next;
      cfg_start   <= cfg_start_next;
      ready       <= ready_next;
      fault       <= fault_next;
    end
  end

  assign retry_cnt = retry_reg;
  assign state_dbg = state_reg;

endmodule
